// File: rtl/selftrigger_frame_capture.sv
// Self-triggered frame capture: a ring buffer keeps a pre-trigger history and, on an
// armed trigger edge, streams a FRAME_LEN-word window out over a valid/ready port.
module selftrigger_frame_capture #(
  parameter int PRETRIG   = 64,
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [15:0] x,
  input  logic               trigger_in,
  input  logic [63:0]        timestamp,
  output logic signed [15:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_first,
  output logic               dout_last,
  output logic [63:0]        ts_out,
  output logic               busy,
  output logic [15:0]        missed_count
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CAP_LEN = FRAME_LEN - PRETRIG - 1;
  localparam logic [ADDR_W:0] PRE_N   = (ADDR_W+1)'(PRETRIG);
  localparam logic [ADDR_W:0] CAP_N   = (ADDR_W+1)'(CAP_LEN);
  localparam logic [ADDR_W:0] LAST_N  = (ADDR_W+1)'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] FRAME_N = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0] ONE_N   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W:0]    primed;
  logic [ADDR_W:0]    cap_cnt;
  logic [ADDR_W:0]    issue_cnt;
  logic               trig_prev;
  logic signed [15:0] mem [DEPTH];
  logic signed [15:0] rd_data_p1;
  logic               vld_p1, first_p1, last_p1;

  logic trig_edge, writing, advance, issue, done;

  assign trig_edge = enable && trigger_in && !trig_prev;
  assign writing   = enable && (state != SEND);
  assign advance   = (state == SEND) && (!dout_valid || dout_ready);
  assign issue     = advance && (issue_cnt < FRAME_N);
  assign done      = dout_valid && dout_ready && dout_last;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // p0 -> p1: buffer write and registered read; the read only advances with the output stage
  always_ff @(posedge clk) begin
    if (writing) mem[wr_ptr] <= x;
    if (issue)   rd_data_p1 <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_addr      <= '0;
      primed       <= '0;
      cap_cnt      <= '0;
      issue_cnt    <= '0;
      trig_prev    <= 1'b0;
      vld_p1       <= 1'b0;
      first_p1     <= 1'b0;
      last_p1      <= 1'b0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      dout_first   <= 1'b0;
      dout_last    <= 1'b0;
      busy         <= 1'b0;
      ts_out       <= '0;
      missed_count <= '0;
    end else begin
      if (enable) trig_prev <= trigger_in;
      if (writing) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (primed != PRE_N) primed <= primed + 1'b1;
      end

      // p1 -> p2: output register; the whole read pipe freezes while the consumer stalls
      if (advance) begin
        vld_p1     <= issue;
        first_p1   <= issue && (issue_cnt == '0);
        last_p1    <= issue && (issue_cnt == LAST_N);
        if (issue) begin
          rd_addr   <= rd_addr + 1'b1;
          issue_cnt <= issue_cnt + 1'b1;
        end
        dout_valid <= vld_p1;
        dout_first <= first_p1;
        dout_last  <= last_p1;
        if (vld_p1) dout <= rd_data_p1;
      end

      case (state)
        IDLE: begin
          if (trig_edge) begin
            if (primed == PRE_N) begin
              rd_addr   <= wr_ptr - ADDR_W'(PRETRIG);
              issue_cnt <= '0;
              ts_out    <= timestamp;
              busy      <= 1'b1;
              cap_cnt   <= CAP_N;
              state     <= (CAP_LEN == 0) ? SEND : CAPTURE;
            end else begin
              missed_count <= sat_inc(missed_count);
            end
          end
        end
        CAPTURE: begin
          if (trig_edge) missed_count <= sat_inc(missed_count);
          if (enable) begin
            if (cap_cnt == ONE_N) state <= SEND;
            cap_cnt <= cap_cnt - 1'b1;
          end
        end
        SEND: begin
          if (trig_edge) missed_count <= sat_inc(missed_count);
          if (done) begin
            state  <= IDLE;
            busy   <= 1'b0;
            primed <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_selftrigger_frame_capture.sv
// Directed bench for selftrigger_frame_capture: ramp stimulus, table of trigger scenarios,
// plus hand sequences for re-arming and reset during frame output.
module tb_selftrigger_frame_capture;

  localparam int FRAME_LEN = 256;
  localparam logic [63:0] TS_BASE = 64'h0123_4567_0000_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [15:0] x;
  logic               trigger_in;
  logic [63:0]        timestamp;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               dout_first;
  logic               dout_last;
  logic [63:0]        ts_out;
  logic               busy;
  logic [15:0]        missed_count;

  selftrigger_frame_capture dut (
    .clk(clk), .reset(reset), .enable(enable), .x(x), .trigger_in(trigger_in),
    .timestamp(timestamp), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_first(dout_first), .dout_last(dout_last), .ts_out(ts_out), .busy(busy),
    .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int sample = 0;
  int ta = -1;
  int tb = -1;
  bit gaps = 1'b0;
  bit rnd  = 1'b0;
  logic [15:0] words[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Output monitor on the falling edge: collects transferred words and checks markers/stalls.
  int         idx = 0;
  bit         stalled = 1'b0;
  logic [17:0] held = '0;
  always @(negedge clk) begin
    if (reset) begin
      idx = 0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(dout_valid), 64'(1));
        chk("stall_hold", 64'({dout_first, dout_last, dout}), 64'(held));
      end
      if (!dout_valid) begin
        chk("idle_markers", 64'({dout_first, dout_last}), 64'(0));
      end else if (dout_ready) begin
        words.push_back(dout);
        chk("first_marker", 64'(dout_first), 64'(idx == 0));
        chk("last_marker", 64'(dout_last), 64'(idx == FRAME_LEN - 1));
        idx = (idx == FRAME_LEN - 1) ? 0 : idx + 1;
      end
      stalled = dout_valid && !dout_ready;
      held = {dout_first, dout_last, dout};
    end
  end

  task automatic tick();
    enable     = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    x          = 16'(sample);
    timestamp  = TS_BASE + 64'(sample);
    trigger_in = (sample == ta) || (sample == tb);
    dout_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    @(posedge clk);
    if (enable) sample++;
    #1;
  endtask

  task automatic run_to(input int stop);
    while (sample < stop) tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 6000) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    trigger_in = 1'b0;
    dout_ready = 1'b1;
    x = '0;
    timestamp = '0;
    @(posedge clk);
    #1;
    chk("rst_outputs", 64'({dout_valid, dout_first, dout_last, busy, dout}), 64'(0));
    chk("rst_ts", ts_out, 64'(0));
    chk("rst_missed", 64'(missed_count), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    sample = 0;
    words.delete();
  endtask

  task automatic check_frame(input string tag, input int first);
    int bad = 0;
    chk({tag, "_len"}, 64'(words.size()), 64'(FRAME_LEN));
    foreach (words[i]) if (words[i] !== 16'(first + i)) bad++;
    chk({tag, "_data"}, 64'(bad), 64'(0));
    chk({tag, "_word0"}, 64'(words.size() > 0 ? words[0] : 16'hFFFF), 64'(16'(first)));
  endtask

  typedef struct {
    string name;
    int    ta;
    int    tb;
    bit    gaps;
    bit    rnd;
    int    first;   // -1: no frame expected
    int    ts;      // sample index of the accepted trigger
    int    missed;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int s;
    int nw;

    vecs[0] = '{"ramp",      1000,   -1, 1'b0, 1'b0, 936,  1000, 0};
    vecs[1] = '{"unprimed",    30,  100, 1'b0, 1'b0,  36,   100, 1};
    vecs[2] = '{"double",    1000, 1050, 1'b0, 1'b0, 936,  1000, 1};
    vecs[3] = '{"stalls",    1000,   -1, 1'b1, 1'b1, 936,  1000, 0};
    vecs[4] = '{"wrap",       564,   -1, 1'b0, 1'b0, 500,   564, 0};
    vecs[5] = '{"edge63",      63,   -1, 1'b0, 1'b0,  -1,     0, 1};
    vecs[6] = '{"edge64",      64,   -1, 1'b0, 1'b0,   0,    64, 0};

    reset = 1'b1;
    for (int v = 0; v < 7; v++) begin
      ta = vecs[v].ta;
      tb = vecs[v].tb;
      gaps = vecs[v].gaps;
      rnd = vecs[v].rnd;
      do_reset();
      run_to(((ta > tb) ? ta : tb) + 10);
      if (vecs[v].first >= 0) begin
        wait_idle(vecs[v].name);
        check_frame(vecs[v].name, vecs[v].first);
        chk({vecs[v].name, "_ts"}, ts_out, TS_BASE + 64'(vecs[v].ts));
      end else begin
        run_to(sample + 300);
        chk({vecs[v].name, "_busy"}, 64'(busy), 64'(0));
        chk({vecs[v].name, "_noframe"}, 64'(words.size()), 64'(0));
      end
      chk({vecs[v].name, "_missed"}, 64'(missed_count), 64'(vecs[v].missed));
    end

    // Re-arm: after a frame, 62 fresh writes are not enough, 64 are.
    gaps = 1'b0;
    rnd = 1'b0;
    ta = 100;
    tb = -1;
    do_reset();
    run_to(110);
    wait_idle("rearm1");
    check_frame("rearm1", 36);
    s = sample;
    words.delete();
    ta = s + 62;
    tb = s + 64;
    run_to(s + 74);
    wait_idle("rearm2");
    check_frame("rearm2", s);
    chk("rearm_missed", 64'(missed_count), 64'(1));
    chk("rearm_ts", ts_out, TS_BASE + 64'(s + 64));

    // Reset while the frame is being sent, after word 100.
    ta = 1000;
    tb = -1;
    do_reset();
    run_to(1010);
    n = 0;
    while (words.size() < 101 && n < 3000) begin
      tick();
      n++;
    end
    chk("midsend_reached", 64'(words.size() >= 101), 64'(1));
    reset = 1'b1;
    #1;
    chk("midsend_rst_out", 64'({dout_valid, dout_first, dout_last, busy, dout}), 64'(0));
    chk("midsend_rst_ts", ts_out, 64'(0));
    nw = words.size();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ta = -1;
    run_to(sample + 400);
    chk("midsend_nowords", 64'(words.size()), 64'(nw));
    chk("midsend_idle", 64'(busy), 64'(0));
    words.delete();
    ta = sample + 100;
    run_to(ta + 10);
    wait_idle("after_rst");
    check_frame("after_rst", ta - 64);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
